// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a two-entry
// (output register + skid) buffer on a valid/ready handshake.
//
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   flush           synchronous flush; empties both entries, drops any offered input
//   in_valid/ready  input handshake; in_ready depends only on registered state
//   in_instr        32-bit instruction word
//   in_imm_type     immediate format (used when DECODE_MODE = 0)
//   in_tag          sideband tag carried alongside the instruction
//   out_valid/ready output handshake
//   out_imm         sign/zero-extended immediate, XLEN bits
//   out_tag         tag belonging to out_imm
//   out_illegal     unsupported format; out_imm is 0 in that case
//
// Formats: 000 I, 001 S, 010 B, 011 U, 100 J, 101 CSR zimm, 110 shamt, 111 illegal.
module imm_gen_pipe #(
  parameter int XLEN        = 64,
  parameter int TAG_W       = 8,
  parameter int DECODE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  localparam logic [2:0] FMT_I     = 3'b000;
  localparam logic [2:0] FMT_S     = 3'b001;
  localparam logic [2:0] FMT_B     = 3'b010;
  localparam logic [2:0] FMT_U     = 3'b011;
  localparam logic [2:0] FMT_J     = 3'b100;
  localparam logic [2:0] FMT_ZIMM  = 3'b101;
  localparam logic [2:0] FMT_SHAMT = 3'b110;
  localparam logic [2:0] FMT_ILL   = 3'b111;

  logic [2:0] fmt;
  logic       sh5;      // 5-bit shift amount (RV32, or RV64 *W shifts)
  entry_t     new_e;
  entry_t     out_q, skid_q;
  logic       out_v, skid_v;
  logic       accept;

  // Opcode only matters in auto-decode mode, the type port only in manual mode.
  logic unused_inputs;
  assign unused_inputs = ^{in_imm_type, in_instr[6:0]};

  // Format selection
  always_comb begin
    fmt = in_imm_type;
    sh5 = (XLEN == 32);
    if (DECODE_MODE != 0) begin
      unique case (in_instr[6:0])
        7'b0000011, 7'b1100111: fmt = FMT_I;
        7'b0010011: fmt = (in_instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
        7'b0011011: begin
          // RV64-only word ops; on RV32 this opcode does not exist
          if (XLEN == 64) begin
            fmt = (in_instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
            sh5 = 1'b1;
          end else begin
            fmt = FMT_ILL;
          end
        end
        7'b0100011:             fmt = FMT_S;
        7'b1100011:             fmt = FMT_B;
        7'b0110111, 7'b0010111: fmt = FMT_U;
        7'b1101111:             fmt = FMT_J;
        7'b1110011:             fmt = in_instr[14] ? FMT_ZIMM : FMT_I;
        default:                fmt = FMT_ILL;
      endcase
    end
  end

  // Immediate extraction; size casts of signed operands sign-extend to XLEN
  always_comb begin
    new_e.tag     = in_tag;
    new_e.illegal = 1'b0;
    new_e.imm     = '0;
    unique case (fmt)
      FMT_I: new_e.imm = XLEN'($signed(in_instr[31:20]));
      FMT_S: new_e.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      FMT_B: new_e.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                        in_instr[11:8], 1'b0}));
      FMT_U: new_e.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      FMT_J: new_e.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                        in_instr[30:21], 1'b0}));
      FMT_ZIMM:  new_e.imm = XLEN'(in_instr[19:15]);
      FMT_SHAMT: new_e.imm = sh5 ? XLEN'(in_instr[24:20]) : XLEN'(in_instr[25:20]);
      default:   new_e.illegal = 1'b1;
    endcase
  end

  // in_ready is purely registered: accept whenever the skid slot is free.
  assign in_ready = !skid_v;
  assign accept   = in_valid && !skid_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || out_ready) begin
      // Output slot frees up: oldest entry (skid) goes first to keep FIFO order.
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= accept;
        if (accept) skid_q <= new_e;
      end else begin
        out_v <= accept;
        if (accept) out_q <= new_e;
      end
    end else if (accept) begin
      // Output stalled: park the new entry in the skid slot.
      skid_v <= 1'b1;
      skid_q <= new_e;
    end
  end

  assign out_valid   = out_v;
  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. Three instances share one stimulus stream:
//   d0: XLEN=64, DECODE_MODE=0   d1: XLEN=64, DECODE_MODE=1   d2: XLEN=32, DECODE_MODE=1
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic [2:0]  in_imm_type = 0;
  logic [7:0]  in_tag = 0;

  logic        ov0, ov1, ov2, ir0, ir1, ir2, il0, il1, il2;
  logic [63:0] imm0, imm1;
  logic [31:0] imm2;
  logic [7:0]  tag0, tag1, tag2;

  int   n_checks = 0, n_fail = 0;
  exp_t q[3][$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .DECODE_MODE(0)) d0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(ov0), .out_ready(out_ready), .out_imm(imm0), .out_tag(tag0), .out_illegal(il0));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .DECODE_MODE(1)) d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(out_ready), .out_imm(imm1), .out_tag(tag1), .out_illegal(il1));
  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .DECODE_MODE(1)) d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(out_ready), .out_imm(imm2), .out_tag(tag2), .out_illegal(il2));

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // sign-extend the low 'bits' bits of v
  function automatic longint sx(longint v, int bits);
    longint m = longint'(1) << bits;
    longint r = v & (m - 1);
    if ((r & (m >> 1)) != 0) r = r - m;
    return r;
  endfunction

  // Reference model: instance k's view of one instruction.
  function automatic exp_t model(int k, logic [31:0] ins, logic [2:0] ty, logic [7:0] tg);
    exp_t   e;
    longint x  = longint'({32'd0, ins});
    int     xl = (k == 2) ? 32 : 64;
    int     f  = int'(ty);
    int     op = int'(ins[6:0]);
    int     f3 = int'(ins[14:12]);
    bit     narrow = (xl == 32);
    longint r = 0;
    if (k != 0) begin
      if (op == 'h03 || op == 'h67) f = 0;
      else if (op == 'h13) f = (f3 == 1 || f3 == 5) ? 6 : 0;
      else if (op == 'h1B && xl == 64) begin f = (f3 == 1 || f3 == 5) ? 6 : 0; narrow = 1; end
      else if (op == 'h23) f = 1;
      else if (op == 'h63) f = 2;
      else if (op == 'h37 || op == 'h17) f = 3;
      else if (op == 'h6F) f = 4;
      else if (op == 'h73) f = ins[14] ? 5 : 0;
      else f = 7;
    end
    case (f)
      0: r = sx(x >> 20, 12);
      1: r = sx(((x >> 25) << 5) | ((x >> 7) & 31), 12);
      2: r = sx(((x >> 31) << 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5)
                | (((x >> 8) & 15) << 1), 13);
      3: r = sx(x & 'hFFFFF000, 32);
      4: r = sx(((x >> 31) << 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11)
                | (((x >> 21) & 1023) << 1), 21);
      5: r = (x >> 15) & 31;
      6: r = narrow ? ((x >> 20) & 31) : ((x >> 20) & 63);
      default: r = 0;
    endcase
    e.imm = (xl == 32) ? (r & 64'h00000000FFFFFFFF) : r;
    e.ill = (f == 7);
    e.tag = tg;
    return e;
  endfunction

  task automatic scb(int k, logic v, logic r, logic [63:0] imm, logic [7:0] tg, logic il);
    exp_t e;
    chk($sformatf("d%0d_out_valid", k), 64'(v), 64'(q[k].size() != 0));
    chk($sformatf("d%0d_in_ready", k), 64'(r), 64'(q[k].size() < 2));
    if (flush) return;
    if (v && out_ready && q[k].size() != 0) begin
      e = q[k].pop_front();
      chk($sformatf("d%0d_imm", k), imm, e.imm);
      chk($sformatf("d%0d_tag", k), 64'(tg), 64'(e.tag));
      chk($sformatf("d%0d_illegal", k), 64'(il), 64'(e.ill));
    end
    if (in_valid && r) q[k].push_back(model(k, in_instr, in_imm_type, in_tag));
  endtask

  // Monitor: inputs change just after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) q[k].delete();
    end else begin
      scb(0, ov0, ir0, imm0, tag0, il0);
      scb(1, ov1, ir1, imm1, tag1, il1);
      scb(2, ov2, ir2, {32'd0, imm2}, tag2, il2);
      if (flush) for (int k = 0; k < 3; k++) q[k].delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 7) != 0)
      case ($urandom_range(0, 11))
        0: r[6:0] = 7'h03;  1: r[6:0] = 7'h67;  2: r[6:0] = 7'h13;  3: r[6:0] = 7'h1B;
        4: r[6:0] = 7'h23;  5: r[6:0] = 7'h63;  6: r[6:0] = 7'h37;  7: r[6:0] = 7'h17;
        8: r[6:0] = 7'h6F;  9: r[6:0] = 7'h73;  10: r[6:0] = 7'h7F; default: r[6:0] = 7'h33;
      endcase
    return r;
  endfunction

  // One instruction into an empty pipe; result must appear one cycle later.
  task automatic dir(logic [31:0] ins, logic [2:0] ty, logic [7:0] tg,
                     logic [63:0] e0, logic [63:0] e1, logic [63:0] e2, logic [2:0] eil);
    in_instr = ins; in_imm_type = ty; in_tag = tg; in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("dir_valid", {ov2, ov1, ov0}, 3'b111);
    chk("dir_imm0", imm0, e0);
    chk("dir_imm1", imm1, e1);
    chk("dir_imm2", {32'd0, imm2}, e2);
    chk("dir_illegal", {il2, il1, il0}, eil);
    chk("dir_tag", {tag2, tag1, tag0}, {tg, tg, tg});
    step();
  endtask

  task automatic drain();
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (6) step();
    chk("drain_empty", q[0].size() + q[1].size() + q[2].size(), 0);
  endtask

  // Two back-to-back entries with output stalled, third held upstream.
  task automatic fill_two_hold_third(logic [7:0] base);
    out_ready = 0; in_valid = 1; in_imm_type = 3'($urandom);
    in_instr = rnd_instr(); in_tag = base;     step();
    in_instr = rnd_instr(); in_tag = base + 1; step();
    in_instr = rnd_instr(); in_tag = base + 2;
    @(negedge clk);
    chk("full_in_ready", {ir2, ir1, ir0}, 3'b000);
    chk("full_out_valid", {ov2, ov1, ov0}, 3'b111);
    chk("full_head_tag", tag0, base);
    step();
  endtask

  initial begin
    bit done;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {ov2, ov1, ov0}, 0);
    chk("rst_in_ready", {ir2, ir1, ir0}, 3'b111);
    chk("rst_imm", imm0 | imm1 | {32'd0, imm2}, 0);
    chk("rst_tag_ill", {tag0, tag1, tag2, il0, il1, il2}, 0);

    dir(32'hFFF00093, 3'd0, 8'h11, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF, 3'b000);
    dir(32'h800000B7, 3'd3, 8'h22, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 64'h80000000, 3'b000);
    dir(32'hFE000EE3, 3'd2, 8'hA5, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFC, 3'b000);
    dir(32'h03F09093, 3'd6, 8'h3C, 64'h3F, 64'h3F, 64'h1F, 3'b000);
    dir(32'h0000007F, 3'd7, 8'h44, 64'h0, 64'h0, 64'h0, 3'b111);
    dir(32'h03F0909B, 3'd5, 8'h55, 64'h1, 64'h1F, 64'h0, 3'b100);
    dir(32'h340FD073, 3'd0, 8'h66, 64'h340, 64'h1F, 64'h1F, 3'b000);

    // Backpressure: A out, B in skid, C held; release and drain in order.
    fill_two_hold_third(8'hA0);
    step();
    out_ready = 1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ir0) begin step(); in_valid = 0; done = 1; end
    end
    if (!done) begin n_checks++; n_fail++; $display("FAIL bp_accept_timeout: C never accepted"); end
    drain();

    // Flush with both entries full and an input offered.
    fill_two_hold_third(8'hB0);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", {ov2, ov1, ov0}, 0);
    chk("flush_in_ready", {ir2, ir1, ir0}, 3'b111);
    step();

    // Randomized traffic with an asynchronous reset mid-stream.
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = (i >= 295 && i < 300) ? 1'b0 : ($urandom_range(0, 9) < 7);
      flush       = (i >= 290 && i < 300) ? 1'b0 : ($urandom_range(0, 39) == 0);
      in_instr    = rnd_instr();
      in_imm_type = 3'($urandom);
      in_tag      = 8'($urandom);
      if (i == 300) begin
        #2 rst = 1;
        #1;
        chk("arst_out_valid", {ov2, ov1, ov0}, 0);
        chk("arst_imm", imm0 | imm1 | {32'd0, imm2}, 0);
        chk("arst_in_ready", {ir2, ir1, ir0}, 3'b111);
        step();
        rst = 0;
      end
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It accepts a 32-bit RISC-V instruction plus an opaque tag over a valid/ready handshake and produces a correctly sign- or zero-extended XLEN immediate one cycle later. A two-entry (output register plus skid) buffer lets decode stall without dropping instructions. It sits between fetch/decode and the ID/EX register. It also supports CSR zimm and shift-amount formats, opcode-driven auto-decode and an illegal-format flag.

Parameters:
XLEN, 64, immediate width; legal values are 32 and 64.
TAG_W, 8, width of the sideband tag carried alongside each instruction (e.g. rd or ROB index).
DECODE_MODE, 0, 0 = immediate type taken from the imm_type port; 1 = immediate type derived from the opcode and imm_type is ignored.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  input instruction valid.
in_ready  out  1  block can accept an input this cycle.
in_instr  in  32  instruction word.
in_imm_type  in  3  immediate format (used when DECODE_MODE=0).
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  output holds a valid result.
out_ready  in  1  downstream accepts the output.
out_imm  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag belonging to out_imm.
out_illegal  out  1  the format was unsupported; out_imm is 0.

Behaviour:
- Reset (asynchronous): out_valid=0, out_imm=0, out_tag=0, out_illegal=0, skid empty. in_ready=1 the cycle reset deasserts.
- Formats (sext = sign-extend to XLEN using instr[31]):
  - 000 I: sext instr[31:20].
  - 001 S: sext {instr[31:25], instr[11:7]}.
  - 010 B: sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: sext {instr[31:12], 12'b0}.
  - 100 J: sext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 101 CSR zimm: zero-extended instr[19:15].
  - 110 shamt: zero-extended instr[25:20] when XLEN=64; instr[24:20] when XLEN=32.
  - 111: illegal; out_imm=0, out_illegal=1.
- DECODE_MODE=1 opcode map:
  - 0000011, 1100111: I.
  - 0010011: shamt if funct3 is 001 or 101, else I.
  - 0011011 (XLEN=64 only): shamt with 5 bits when funct3 is 001 or 101, else I.
  - 0100011: S. 1100011: B. 0110111 and 0010111: U. 1101111: J.
  - 1110011: zimm if instr[14]=1, else I.
  - Any other opcode: illegal.
- Handshake: transfer on in_valid && in_ready; output consumed on out_valid && out_ready. in_ready = skid empty; it is a registered-state function with no combinational path from out_ready.
- Latency: an accepted instruction is visible on out_* the next cycle when the output register is empty or being consumed; otherwise it lands in the skid entry.
- Ordering: strict FIFO. When the output register is consumed and the skid is full, the skid moves into the output register and a same-cycle input goes to the skid.
- Full case: output register and skid both occupied -> in_ready=0. Input is held upstream and no data is lost.
- Outputs are stable while out_valid && !out_ready.
- Flush: highest priority over accept and consume. Next cycle both entries are empty and out_valid=0; an input offered in the flush cycle is discarded. out_imm and out_tag may hold stale values while out_valid=0.
- Reset mid-operation: all entries are dropped immediately and in-flight data is lost.

Test Plan:
- XLEN=64, type 000, instr 0xFFF00093 -> 1 cycle later out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_illegal=0.
- Type 011, instr 0x800000B7 -> out_imm=0xFFFFFFFF80000000; with XLEN=32 -> 0x80000000.
- Type 010, instr 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFFFFFFFFFC, and the tag passes through unchanged.
- DECODE_MODE=1, XLEN=64: instr 0x03F09093 (slli x1,x1,63) -> out_imm=0x3F; instr 0x0000007F -> out_illegal=1, out_imm=0.
- Backpressure: out_ready=0 while sending tags A, B, C back-to-back -> A on the output, B in the skid, in_ready=0 with C held. Raise out_ready -> outputs A, B, C in consecutive cycles, no loss or duplication.
- Flush with both entries full -> next cycle out_valid=0, in_ready=1. Assert rst asynchronously mid-stream -> out_valid=0 and out_imm=0 immediately, without waiting for a clock edge.
